// File: rtl/serial_rx_framer.sv
// serial_rx_framer: recovers start/DATA_WIDTH-bit LSB-first/stop frames from an idle-high line, mid-bit sampled.
// Define SERIAL_RX_FRAMER_PARITY_EN to add an even-parity bit between data and stop.
module serial_rx_framer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  d_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  parity_err_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`ifdef SERIAL_RX_FRAMER_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
    assign parity_err_o = 1'b0;
`endif
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] sh;
    logic                  par_bad;
    logic                  samp;
    assign samp   = cnt == '0;
    assign busy_o = state != IDLE;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            par_bad     <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef SERIAL_RX_FRAMER_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else if (clr_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            par_bad     <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef SERIAL_RX_FRAMER_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef SERIAL_RX_FRAMER_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (en_i) begin
                if (state != IDLE && state != BREAK)
                    cnt <= samp ? CW'(CLKS_PER_BIT - 1) : cnt - 1'b1;
                case (state)
                    IDLE: if (!d_i) begin
                        state   <= START;
                        cnt     <= CW'(CLKS_PER_BIT / 2 - 1);
                        par_bad <= 1'b0;
                    end
                    START: if (samp) begin
                        state   <= d_i ? IDLE : DATA;
                        bit_idx <= '0;
                    end
                    DATA: if (samp) begin
                        sh      <= (sh >> 1) | (DATA_WIDTH'(d_i) << (DATA_WIDTH - 1));
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BW'(DATA_WIDTH - 1)) state <= AFTER_DATA;
                    end
`ifdef SERIAL_RX_FRAMER_PARITY_EN
                    PARITY: if (samp) begin
                        state <= STOP;
                        if (d_i != ^sh) begin
                            parity_err_o <= 1'b1;
                            par_bad      <= 1'b1;
                        end
                    end
`endif
                    STOP: if (samp) begin
                        if (d_i) begin
                            state <= IDLE;
                            // a parity-failed word is dropped silently
                            if (!par_bad) begin
                                if (!valid_o || ready_i) begin
                                    data_o  <= sh;
                                    valid_o <= 1'b1;
                                end else begin
                                    overrun_o <= 1'b1;
                                end
                            end
                        end else begin
                            state       <= BREAK;
                            frame_err_o <= 1'b1;
                        end
                    end
                    BREAK: if (d_i) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_framer.sv
// tb_serial_rx_framer: frame-level checks of serial_rx_framer (tables, hand sequences, random frames vs word queue model).
module tb_serial_rx_framer;
    localparam int DW   = 8;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef SERIAL_RX_FRAMER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int STOP_AT = HALF + (DW + 1 + PB) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1, clr = 1'b0, en = 1'b1, d = 1'b1, ready = 1'b1;
    logic [DW-1:0] data;
    logic valid, ferr, ovr, perr, busy;

    serial_rx_framer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .d_i(d),
        .data_o(data), .valid_o(valid), .ready_i(ready),
        .frame_err_o(ferr), .overrun_o(ovr), .parity_err_o(perr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_got = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [DW-1:0] got [0:1023];

    always @(posedge clk) begin
        if (valid && ready) begin
            got[n_got] = data;
            n_got = n_got + 1;
        end
        n_ferr = n_ferr + int'(ferr);
        n_ovr  = n_ovr + int'(ovr);
        n_perr = n_perr + int'(perr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        d = 1'b1;
        cyc(n);
    endtask

    // drives one frame from a negedge; tog halves the enable rate and doubles the bit length in clocks
    task automatic send(input logic [DW-1:0] v, input logic stop, input bit tog, input bit bad_par);
        int per;
        logic lv;
        per = tog ? 2 * CPB : CPB;
        for (int b = 0; b < DW + 2 + PB; b++) begin
            if (b == 0) lv = 1'b0;
            else if (b <= DW) lv = v[b-1];
            else if (PB == 1 && b == DW + 1) lv = (^v) ^ bad_par;
            else lv = stop;
            for (int k = 0; k < per; k++) begin
                d  = lv;
                en = tog ? (k % 2 == 0) : 1'b1;
                @(negedge clk);
            end
        end
        en = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] v;
        logic          stop;
        int            exp_words;
        int            exp_ferr;
    } vec_t;

    vec_t tbl [6];
    logic [DW-1:0] exp_q [$];

    initial begin
        int g0, f0, o0, p0, ef;
        logic [DW-1:0] rv;
        logic rs;
        tbl[0] = '{8'h00, 1'b1, 1, 0};
        tbl[1] = '{8'hFF, 1'b1, 1, 0};
        tbl[2] = '{8'h80, 1'b1, 1, 0};
        tbl[3] = '{8'h01, 1'b1, 1, 0};
        tbl[4] = '{8'hAA, 1'b0, 0, 1};
        tbl[5] = '{8'h7E, 1'b0, 0, 1};

        cyc(3);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'd0, ferr, ovr, perr}, 0);
        rst = 1'b0;
        idle(4);

        fork
            send(8'hA5, 1'b1, 1'b0, 1'b0);
            begin
                @(posedge clk);
                repeat (STOP_AT - 1) @(posedge clk);
                #1 chk("lat_valid_early", 32'(valid), 0);
                @(posedge clk);
                #1 chk("lat_valid", 32'(valid), 1);
                chk("lat_data", 32'(data), 32'hA5);
                @(posedge clk);
                #1 chk("lat_valid_clear", 32'(valid), 0);
            end
        join
        chk("lat_no_ferr", 32'(ferr | ovr), 0);
        idle(4);

        f0 = n_ferr; g0 = n_got;
        d = 1'b0;
        cyc(1);
        chk("fs_busy_start", 32'(busy), 1);
        cyc(4);
        d = 1'b1;
        cyc(3);
        chk("fs_busy_pre", 32'(busy), 1);
        cyc(1);
        chk("fs_busy_idle", 32'(busy), 0);
        cyc(5);
        chk("fs_no_word", 32'(n_got - g0), 0);
        chk("fs_no_ferr", 32'(n_ferr - f0), 0);

        g0 = n_got;
        fork
            send(8'h3C, 1'b0, 1'b0, 1'b0);
            begin
                @(posedge clk);
                repeat (STOP_AT - 1) @(posedge clk);
                #1 chk("fe_pre", 32'(ferr), 0);
                @(posedge clk);
                #1 chk("fe_pulse", 32'(ferr), 1);
                @(posedge clk);
                #1 chk("fe_post", 32'(ferr), 0);
            end
        join
        cyc(40);
        chk("fe_break_busy", 32'(busy), 1);
        d = 1'b1;
        cyc(1);
        chk("fe_break_exit", 32'(busy), 0);
        chk("fe_no_word", 32'(n_got - g0), 0);
        idle(4);

        ready = 1'b0;
        o0 = n_ovr; g0 = n_got;
        send(8'h11, 1'b1, 1'b0, 1'b0);
        idle(4);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("ov_valid", 32'(valid), 1);
        chk("ov_data", 32'(data), 32'h11);
        chk("ov_count", 32'(n_ovr - o0), 1);
        ready = 1'b1;
        cyc(1);
        chk("ov_drop_valid", 32'(valid), 0);
        chk("ov_words", 32'(n_got - g0), 1);
        chk("ov_word", 32'(got[g0]), 32'h11);

        ready = 1'b0;
        fork
            send(8'h5A, 1'b1, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (2 * STOP_AT - 1) @(posedge clk);
                #1 chk("en_valid_early", 32'(valid), 0);
                @(posedge clk);
                #1 chk("en_valid", 32'(valid), 1);
                chk("en_data", 32'(data), 32'h5A);
            end
        join
        ready = 1'b1;
        idle(4);

        g0 = n_got; f0 = n_ferr;
        fork
            send(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                cyc(60);
                rst = 1'b1;
                cyc(1);
                chk("rst_mid_busy", 32'(busy), 0);
                rst = 1'b0;
            end
        join
        idle(4);
        send(8'h01, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("rst_words", 32'(n_got - g0), 1);
        chk("rst_word", 32'(got[g0]), 32'h01);
        chk("rst_no_ferr", 32'(n_ferr - f0), 0);

        g0 = n_got;
        fork
            send(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                cyc(40);
                clr = 1'b1;
                cyc(1);
                chk("clr_busy", 32'(busy), 0);
                clr = 1'b0;
            end
        join
        idle(4);
        chk("clr_no_word", 32'(n_got - g0), 0);

`ifdef SERIAL_RX_FRAMER_PARITY_EN
        g0 = n_got; p0 = n_perr;
        send(8'h07, 1'b1, 1'b0, 1'b1);
        idle(4);
        chk("par_pulse", 32'(n_perr - p0), 1);
        chk("par_no_word", 32'(n_got - g0), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            g0 = n_got; f0 = n_ferr;
            send(tbl[i].v, tbl[i].stop, 1'b0, 1'b0);
            idle(6);
            chk($sformatf("tbl%0d_words", i), 32'(n_got - g0), 32'(tbl[i].exp_words));
            if (tbl[i].exp_words == 1) chk($sformatf("tbl%0d_data", i), 32'(got[g0]), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_ferr", i), 32'(n_ferr - f0), 32'(tbl[i].exp_ferr));
        end

        g0 = n_got; f0 = n_ferr; p0 = n_perr; o0 = n_ovr; ef = 0;
        for (int i = 0; i < 20; i++) begin
            rv = DW'($urandom);
            rs = $urandom_range(3) != 0;
            if (rs) exp_q.push_back(rv);
            else ef++;
            send(rv, rs, 1'b0, 1'b0);
            idle($urandom_range(1, 6));
        end
        idle(4);
        chk("rnd_words", 32'(n_got - g0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && g0 + i < n_got; i++)
            chk($sformatf("rnd_word%0d", i), 32'(got[g0+i]), 32'(exp_q[i]));
        chk("rnd_ferr", 32'(n_ferr - f0), 32'(ef));
        chk("rnd_ovr", 32'(n_ovr - o0), 0);
        chk("rnd_perr", 32'(n_perr - p0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
